// File: rtl/sdram_write_burst.sv
// sdram_write_burst: PRECHARGE -> ACTIVE -> N back-to-back WRITE bursts in one
// row, then write recovery and a one-cycle ack. Timing, burst length and the
// address split are parameters; the burst count is a runtime input. A pending
// refresh (aref_req) cuts the sequence short at the next burst boundary.
//
// Optional build macro SDRAM_AUTO_PRECHARGE_EN: skip the explicit PRECHARGE,
// put A10=1 on the final WRITE and stretch recovery to T_WR+T_RP cycles.
//
// Every output is a flop. The command flops are loaded from the state that was
// current on the previous cycle, so each command appears one cycle after its
// state is entered (write_en sampled at edge 0 -> first command at edge 1).
module sdram_write_burst #(
    parameter int ROW_W     = 12,
    parameter int COL_W     = 8,
    parameter int BANK_W    = 2,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 4,
    parameter int T_RP      = 2,
    parameter int T_RCD     = 2,
    parameter int T_WR      = 2
) (
    input  logic                          S_CLK,
    input  logic                          RST_N,
    input  logic                          write_en,
    input  logic [BANK_W+ROW_W+COL_W-1:0] sdram_addr,
    input  logic [CNT_W-1:0]              n_bursts,
    input  logic                          aref_req,
    output logic                          write_busy,
    output logic                          write_ack,
    output logic                          write_partial,
    output logic [CNT_W-1:0]              bursts_done,
    output logic                          fifo_rd_req,
    output logic [ROW_W-1:0]              write_addr,
    output logic [BANK_W-1:0]             write_ba,
    output logic [4:0]                    write_cmd
);

    // {CKE,CS_N,RAS_N,CAS_N,WE_N}
    localparam logic [4:0] CMD_NOP  = 5'b10111;
    localparam logic [4:0] CMD_PREC = 5'b10010;
    localparam logic [4:0] CMD_ACT  = 5'b10011;
    localparam logic [4:0] CMD_WR   = 5'b10100;

    // A10 alone: precharge-all / reset value of the A bus
    localparam logic [ROW_W-1:0] ADDR_A10 = ROW_W'(1024);

    localparam int TMR_W = 8;
`ifdef SDRAM_AUTO_PRECHARGE_EN
    localparam int WREC_CYC = T_WR + T_RP;
    // cycle inside WREC where an explicit precharge goes after an early stop
    localparam logic [TMR_W-1:0] WR_IDX = TMR_W'(T_WR);
`else
    localparam int WREC_CYC = T_WR;
`endif
    localparam logic [TMR_W-1:0] RP_LAST   = TMR_W'(T_RP - 1);
    localparam logic [TMR_W-1:0] RCD_LAST  = TMR_W'(T_RCD - 1);
    localparam logic [TMR_W-1:0] WREC_LAST = TMR_W'(WREC_CYC - 1);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PREC, S_ACT, S_WRITE, S_WREC, S_DONE
    } state_t;

    state_t state_q, state_d;

    // sequencing counters and latched request
    logic [TMR_W-1:0]  cnt_q, cnt_d;       // cycles spent in PREC/ACT/WREC
    logic [BEAT_W-1:0] beat_q, beat_d;     // beat index inside current burst
    logic [CNT_W-1:0]  burst_q, burst_d;   // bursts completed so far
    logic [CNT_W-1:0]  nb_q, nb_d;         // requested bursts, never 0
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;       // column of the current burst
    logic              part_q, part_d;     // stopped early for refresh

    // output flops
    logic [4:0]        cmd_q, cmd_d;
    logic [ROW_W-1:0]  addr_q, addr_d;
    logic [BANK_W-1:0] ba_q, ba_d;
    logic              fifo_q, fifo_d;
    logic              ack_q, ack_d;
    logic              partial_q, partial_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  done_q, done_d;

    logic last_burst;   // current burst is the last one by count
    logic at_bnd;       // current cycle is the last data beat of a burst
    logic stop;         // leave WRITE after this beat
    logic accept;

    assign accept     = (state_q == S_IDLE) && write_en;
    assign last_burst = (burst_q + CNT_W'(1)) == nb_q;
    assign at_bnd     = (state_q == S_WRITE) && (beat_q == BEAT_LAST);
    assign stop       = at_bnd && (last_burst || aref_req);

    // state register
    always_ff @(posedge S_CLK) begin
        if (!RST_N) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (write_en) begin
`ifdef SDRAM_AUTO_PRECHARGE_EN
                    state_d = S_ACT;
`else
                    state_d = S_PREC;
`endif
                end
            end
            S_PREC:  if (cnt_q == RP_LAST)   state_d = S_ACT;
            S_ACT:   if (cnt_q == RCD_LAST)  state_d = S_WRITE;
            S_WRITE: if (stop)               state_d = S_WREC;
            S_WREC:  if (cnt_q == WREC_LAST) state_d = S_DONE;
            S_DONE:                          state_d = S_IDLE;
            default:                         state_d = S_IDLE;
        endcase
    end

    // counters, request latch and refresh-stop flag
    always_comb begin
        cnt_d   = (state_d != state_q) ? '0 : cnt_q + TMR_W'(1);
        beat_d  = '0;
        burst_d = burst_q;
        nb_d    = nb_q;
        bank_d  = bank_q;
        row_d   = row_q;
        col_d   = col_q;
        part_d  = part_q;
        if (accept) begin
            {bank_d, row_d, col_d} = sdram_addr;
            nb_d    = (n_bursts == '0) ? CNT_W'(1) : n_bursts;
            burst_d = '0;
            part_d  = 1'b0;
        end
        if (state_q == S_WRITE)
            beat_d = (beat_q == BEAT_LAST) ? '0 : beat_q + BEAT_W'(1);
        if (at_bnd) begin
            burst_d = burst_q + CNT_W'(1);
            // column wraps inside the row; row is never advanced
            col_d   = col_q + COL_W'(BURST_LEN);
            if (!last_burst && aref_req) part_d = 1'b1;
        end
    end

    // output decode, registered below
    always_comb begin
        cmd_d     = CMD_NOP;
        addr_d    = addr_q;
        ba_d      = ba_q;
        fifo_d    = 1'b0;
        ack_d     = 1'b0;
        partial_d = partial_q;
        done_d    = done_q;
        busy_d    = (state_q != S_IDLE);
        case (state_q)
            S_PREC: begin
                if (cnt_q == '0) begin
                    cmd_d  = CMD_PREC;
                    addr_d = ADDR_A10;
                end
            end
            S_ACT: begin
                if (cnt_q == '0) begin
                    cmd_d  = CMD_ACT;
                    addr_d = row_q;
                    ba_d   = bank_q;
                end
                // FIFO has one cycle of read latency: request ahead of WRITE
                if (cnt_q == RCD_LAST) fifo_d = 1'b1;
            end
            S_WRITE: begin
                if (beat_q == '0) begin
                    cmd_d              = CMD_WR;
                    addr_d             = '0;
                    addr_d[COL_W-1:0]  = col_q;
`ifdef SDRAM_AUTO_PRECHARGE_EN
                    addr_d[10]         = last_burst;
`endif
                end
                // keep strobing unless this is the final beat of the sequence
                fifo_d = (beat_q != BEAT_LAST) || (!last_burst && !aref_req);
            end
            S_WREC: begin
`ifdef SDRAM_AUTO_PRECHARGE_EN
                // an early stop left the row open: close it after tWR
                if (part_q && cnt_q == WR_IDX) begin
                    cmd_d  = CMD_PREC;
                    addr_d = ADDR_A10;
                end
`endif
            end
            S_DONE: begin
                ack_d     = 1'b1;
                partial_d = part_q;
                done_d    = burst_q;
            end
            default: ;
        endcase
    end

    // datapath and output registers
    always_ff @(posedge S_CLK) begin
        if (!RST_N) begin
            cnt_q     <= '0;
            beat_q    <= '0;
            burst_q   <= '0;
            nb_q      <= CNT_W'(1);
            bank_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            part_q    <= 1'b0;
            cmd_q     <= CMD_NOP;
            addr_q    <= ADDR_A10;
            ba_q      <= '0;
            fifo_q    <= 1'b0;
            ack_q     <= 1'b0;
            partial_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            beat_q    <= beat_d;
            burst_q   <= burst_d;
            nb_q      <= nb_d;
            bank_q    <= bank_d;
            row_q     <= row_d;
            col_q     <= col_d;
            part_q    <= part_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            ba_q      <= ba_d;
            fifo_q    <= fifo_d;
            ack_q     <= ack_d;
            partial_q <= partial_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign write_cmd     = cmd_q;
    assign write_addr    = addr_q;
    assign write_ba      = ba_q;
    assign fifo_rd_req   = fifo_q;
    assign write_ack     = ack_q;
    assign write_partial = partial_q;
    assign write_busy    = busy_q;
    assign bursts_done   = done_q;

endmodule

// File: tb/tb_sdram_write_burst.sv
// Directed bench for sdram_write_burst at default parameters. Each scenario
// samples write_en at "edge 0" and records every output for the following
// NREC edges; expectations are hand-computed edge numbers and values.
module tb_sdram_write_burst;

    localparam int NREC = 24;
    localparam logic [31:0] NOP  = 32'h17;
    localparam logic [31:0] PREC = 32'h12;
    localparam logic [31:0] ACT  = 32'h13;
    localparam logic [31:0] WR   = 32'h14;

    logic        S_CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        write_en = 1'b0;
    logic [21:0] sdram_addr = '0;
    logic [3:0]  n_bursts = '0;
    logic        aref_req = 1'b0;
    logic        write_busy, write_ack, write_partial, fifo_rd_req;
    logic [3:0]  bursts_done;
    logic [11:0] write_addr;
    logic [1:0]  write_ba;
    logic [4:0]  write_cmd;

    int n_chk = 0;
    int n_err = 0;

    logic [4:0]  cmd_r  [0:NREC];
    logic [11:0] addr_r [0:NREC];
    logic [1:0]  ba_r   [0:NREC];
    logic        fifo_r [0:NREC];
    logic        ack_r  [0:NREC];
    logic        busy_r [0:NREC];
    logic        part_r [0:NREC];
    logic [3:0]  done_r [0:NREC];

    sdram_write_burst dut (
        .S_CLK        (S_CLK),
        .RST_N        (RST_N),
        .write_en     (write_en),
        .sdram_addr   (sdram_addr),
        .n_bursts     (n_bursts),
        .aref_req     (aref_req),
        .write_busy   (write_busy),
        .write_ack    (write_ack),
        .write_partial(write_partial),
        .bursts_done  (bursts_done),
        .fifo_rd_req  (fifo_rd_req),
        .write_addr   (write_addr),
        .write_ba     (write_ba),
        .write_cmd    (write_cmd)
    );

    always #5 S_CLK = ~S_CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int n_fifo();
        int s = 0;
        for (int k = 1; k <= NREC; k++) if (fifo_r[k]) s++;
        return s;
    endfunction

    function automatic int first_fifo();
        for (int k = 1; k <= NREC; k++) if (fifo_r[k]) return k;
        return -1;
    endfunction

    function automatic int last_fifo();
        for (int k = NREC; k >= 1; k--) if (fifo_r[k]) return k;
        return -1;
    endfunction

    function automatic int ack_at();
        for (int k = 1; k <= NREC; k++) if (ack_r[k]) return k;
        return -1;
    endfunction

    function automatic int n_cmd(input logic [31:0] c);
        int s = 0;
        for (int k = 1; k <= NREC; k++) if (32'(cmd_r[k]) == c) s++;
        return s;
    endfunction

    // One transaction: write_en sampled at edge 0, outputs recorded at edges
    // 1..NREC. aref_at/wen_at/rst_at (-1 = unused) inject events after edge k.
    task automatic run(input logic [1:0] bank, input logic [11:0] row, input logic [7:0] col,
                       input logic [3:0] n, input int aref_at, input int wen_at, input int rst_at);
        @(negedge S_CLK);
        write_en   = 1'b1;
        sdram_addr = {bank, row, col};
        n_bursts   = n;
        @(posedge S_CLK);
        #1;
        write_en   = 1'b0;
        sdram_addr = '0;
        n_bursts   = '0;
        for (int k = 1; k <= NREC; k++) begin
            @(posedge S_CLK);
            #1;
            cmd_r[k]  = write_cmd;
            addr_r[k] = write_addr;
            ba_r[k]   = write_ba;
            fifo_r[k] = fifo_rd_req;
            ack_r[k]  = write_ack;
            busy_r[k] = write_busy;
            part_r[k] = write_partial;
            done_r[k] = bursts_done;
            if (k == aref_at)    aref_req = 1'b1;
            if (k + 1 == wen_at) write_en = 1'b1;
            if (k == wen_at)     write_en = 1'b0;
            if (k + 1 == rst_at) RST_N = 1'b0;
            if (k == rst_at)     RST_N = 1'b1;
        end
        aref_req = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge S_CLK);
        #1;
        chk("rst_cmd",  32'(write_cmd), NOP);
        chk("rst_addr", 32'(write_addr), 32'h400);
        chk("rst_ba",   32'(write_ba), 0);
        chk("rst_fifo", 32'(fifo_rd_req), 0);
        chk("rst_ack",  32'(write_ack), 0);
        chk("rst_part", 32'(write_partial), 0);
        chk("rst_busy", 32'(write_busy), 0);
        chk("rst_done", 32'(bursts_done), 0);
        RST_N = 1'b1;
        repeat (2) @(posedge S_CLK);

        // single burst
        run(2'd1, 12'h123, 8'h10, 4'd1, -1, -1, -1);
        chk("s1_prec",      32'(cmd_r[1]), PREC);
        chk("s1_prec_addr", 32'(addr_r[1]), 32'h400);
        chk("s1_nop2",      32'(cmd_r[2]), NOP);
        chk("s1_act",       32'(cmd_r[3]), ACT);
        chk("s1_act_addr",  32'(addr_r[3]), 32'h123);
        chk("s1_act_ba",    32'(ba_r[3]), 1);
        chk("s1_wr",        32'(cmd_r[5]), WR);
        chk("s1_wr_addr",   32'(addr_r[5]), 32'h010);
        chk("s1_wr_ba",     32'(ba_r[5]), 1);
        chk("s1_fifo_first", first_fifo(), 4);
        chk("s1_fifo_last",  last_fifo(), 7);
        chk("s1_fifo_n",     n_fifo(), 4);
        chk("s1_ack",        ack_at(), 11);
        chk("s1_done",      32'(done_r[11]), 1);
        chk("s1_part",      32'(part_r[11]), 0);
        chk("s1_busy1",     32'(busy_r[1]), 1);
        chk("s1_busy11",    32'(busy_r[11]), 1);
        chk("s1_busy12",    32'(busy_r[12]), 0);

        // three bursts, column stepping
        run(2'd2, 12'h2AB, 8'h00, 4'd3, -1, -1, -1);
        chk("s2_wr1",      32'(cmd_r[5]), WR);
        chk("s2_wr1_addr", 32'(addr_r[5]), 32'h000);
        chk("s2_wr2",      32'(cmd_r[9]), WR);
        chk("s2_wr2_addr", 32'(addr_r[9]), 32'h004);
        chk("s2_wr3",      32'(cmd_r[13]), WR);
        chk("s2_wr3_addr", 32'(addr_r[13]), 32'h008);
        chk("s2_wr_n",     n_cmd(WR), 3);
        chk("s2_fifo_first", first_fifo(), 4);
        chk("s2_fifo_last",  last_fifo(), 15);
        chk("s2_fifo_n",     n_fifo(), 12);
        chk("s2_ack",        ack_at(), 19);
        chk("s2_done",     32'(done_r[19]), 3);
        chk("s2_ba",       32'(ba_r[13]), 2);

        // column wrap inside the row
        run(2'd3, 12'h055, 8'hFC, 4'd2, -1, -1, -1);
        chk("s3_act_addr", 32'(addr_r[3]), 32'h055);
        chk("s3_wr1_addr", 32'(addr_r[5]), 32'h0FC);
        chk("s3_wr2",      32'(cmd_r[9]), WR);
        chk("s3_wr2_addr", 32'(addr_r[9]), 32'h000);
        chk("s3_wr2_ba",   32'(ba_r[9]), 3);
        chk("s3_act_n",    n_cmd(ACT), 1);
        chk("s3_ack",      ack_at(), 15);
        chk("s3_done",     32'(done_r[15]), 2);

        // refresh request cuts four bursts down to one
        run(2'd0, 12'h321, 8'h20, 4'd4, 6, -1, -1);
        chk("s4_ack",    ack_at(), 11);
        chk("s4_part",   32'(part_r[11]), 1);
        chk("s4_done",   32'(done_r[11]), 1);
        chk("s4_fifo_n", n_fifo(), 4);
        chk("s4_wr_n",   n_cmd(WR), 1);

        // extra write_en mid-operation ignored, then reset aborts
        run(2'd1, 12'h0F0, 8'h40, 4'd2, -1, 3, 6);
        chk("s5_act",     32'(cmd_r[3]), ACT);
        chk("s5_prec_n",  n_cmd(PREC), 1);
        chk("s5_rst_cmd", 32'(cmd_r[6]), NOP);
        chk("s5_rst_fifo",32'(fifo_r[6]), 0);
        chk("s5_rst_busy",32'(busy_r[6]), 0);
        chk("s5_no_ack",  ack_at(), -1);
        chk("s5_idle",    32'(busy_r[12]), 0);

        // n_bursts=0 behaves as one burst
        run(2'd1, 12'h123, 8'h10, 4'd0, -1, -1, -1);
        chk("s6_prec",   32'(cmd_r[1]), PREC);
        chk("s6_wr",     32'(cmd_r[5]), WR);
        chk("s6_wr_n",   n_cmd(WR), 1);
        chk("s6_fifo_n", n_fifo(), 4);
        chk("s6_ack",    ack_at(), 11);
        chk("s6_done",   32'(done_r[11]), 1);
        chk("s6_part",   32'(part_r[11]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
